// File: rtl/vx_commit_sink.sv
// Commit-interface sink: 2-entry skid buffer feeding GPR writeback, per-warp sop/eop tracking, retire pulses.
// Optional COMMIT_SINK_PERF_EN adds perf_retired / perf_stalls counters.

module vx_commit_sink_lane #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load0_in,
    input  logic            load0_e1,
    input  logic            load1_in,
    input  logic [XLEN-1:0] in_data,
    output logic [XLEN-1:0] out_data
);
    logic [XLEN-1:0] e1_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            e1_data  <= '0;
        end else begin
            if (load0_e1)
                out_data <= e1_data;
            else if (load0_in)
                out_data <= in_data;
            if (load1_in)
                e1_data <= in_data;
        end
    end
endmodule

module vx_commit_sink #(
    parameter int NUM_LANES  = 4,
    parameter int PID_WIDTH  = 1,
    parameter int UUID_WIDTH = 44,
    parameter int NW_WIDTH   = 2,
    parameter int PC_BITS    = 30,
    parameter int NR_BITS    = 5,
    parameter int XLEN       = 32,
    parameter int RRS_WIS_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [UUID_WIDTH-1:0]     in_uuid,
    input  logic [NW_WIDTH-1:0]       in_wid,
    input  logic [NUM_LANES-1:0]      in_tmask,
    input  logic [PC_BITS-1:0]        in_PC,
    input  logic                      in_wb,
    input  logic [NR_BITS-1:0]        in_rd,
    input  logic [NUM_LANES*XLEN-1:0] in_data,
    input  logic [PID_WIDTH-1:0]      in_pid,
    input  logic                      in_sop,
    input  logic                      in_eop,
    input  logic [RRS_WIS_W-1:0]      in_rrs_id,
    output logic                      in_ready,
    output logic                      wb_valid,
    output logic                      wb_we,
    output logic [NW_WIDTH-1:0]       wb_wid,
    output logic [NR_BITS-1:0]        wb_rd,
    output logic [NUM_LANES-1:0]      wb_tmask,
    output logic [NUM_LANES*XLEN-1:0] wb_data,
    output logic [PID_WIDTH-1:0]      wb_pid,
    output logic [RRS_WIS_W-1:0]      wb_rrs_id,
    input  logic                      wb_ready,
    output logic                      retire_valid,
    output logic [NW_WIDTH-1:0]       retire_wid,
    output logic [RRS_WIS_W-1:0]      retire_rrs_id,
    output logic                      err,
    output logic [NW_WIDTH-1:0]       err_wid
`ifdef COMMIT_SINK_PERF_EN
    ,
    output logic [43:0]               perf_retired,
    output logic [43:0]               perf_stalls
`endif
);
    localparam int NUM_WARPS = 1 << NW_WIDTH;

    typedef struct packed {
        logic [NW_WIDTH-1:0]  wid;
        logic [NUM_LANES-1:0] tmask;
        logic                 wb;
        logic [NR_BITS-1:0]   rd;
        logic [PID_WIDTH-1:0] pid;
        logic [RRS_WIS_W-1:0] rrs_id;
    } meta_t;

    meta_t in_meta, e0, e1;
    logic  e0_valid, e1_valid;
    logic  accept, pop, load0_in, load0_e1, load1_in;

    // uuid and PC travel with the packet upstream but are not needed at writeback
    logic unused_fields;
    assign unused_fields = ^{in_uuid, in_PC};

    assign in_meta = '{wid: in_wid, tmask: in_tmask, wb: in_wb, rd: in_rd,
                       pid: in_pid, rrs_id: in_rrs_id};

    // in_ready comes straight from a flop so upstream never sees a wb_ready path
    assign in_ready = !e1_valid;
    assign accept   = in_valid && in_ready;
    assign pop      = e0_valid && wb_ready;
    assign load0_e1 = pop && e1_valid;
    assign load0_in = accept && (!e0_valid || (pop && !e1_valid));
    assign load1_in = accept && e0_valid && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e0_valid <= 1'b0;
            e1_valid <= 1'b0;
            e0       <= '0;
            e1       <= '0;
        end else begin
            e0_valid <= load0_in || load0_e1 || (e0_valid && !pop);
            e1_valid <= load1_in || (e1_valid && !pop);
            if (load0_e1)
                e0 <= e1;
            else if (load0_in)
                e0 <= in_meta;
            if (load1_in)
                e1 <= in_meta;
        end
    end

    logic [NUM_LANES-1:0][XLEN-1:0] in_lanes, wb_lanes;
    assign in_lanes = in_data;
    assign wb_data  = wb_lanes;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        vx_commit_sink_lane #(.XLEN(XLEN)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load0_in (load0_in),
            .load0_e1 (load0_e1),
            .load1_in (load1_in),
            .in_data  (in_lanes[g]),
            .out_data (wb_lanes[g])
        );
    end

    assign wb_valid  = e0_valid;
    assign wb_we     = e0_valid && e0.wb && (|e0.tmask);
    assign wb_wid    = e0.wid;
    assign wb_rd     = e0.rd;
    assign wb_tmask  = e0.tmask;
    assign wb_pid    = e0.pid;
    assign wb_rrs_id = e0.rrs_id;

    // a sop must arrive on a closed warp and a non-sop on an open one
    logic [NUM_WARPS-1:0] in_flight;
    logic                 violation;
    assign violation = accept && (in_sop == in_flight[in_wid]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight     <= '0;
            err           <= 1'b0;
            err_wid       <= '0;
            retire_valid  <= 1'b0;
            retire_wid    <= '0;
            retire_rrs_id <= '0;
        end else begin
            if (accept && in_sop && !in_eop)
                in_flight[in_wid] <= 1'b1;
            else if (accept && !in_sop && in_eop)
                in_flight[in_wid] <= 1'b0;
            if (violation && !err) begin
                err     <= 1'b1;
                err_wid <= in_wid;
            end
            retire_valid <= accept && in_eop;
            if (accept && in_eop) begin
                retire_wid    <= in_wid;
                retire_rrs_id <= in_rrs_id;
            end
        end
    end

`ifdef COMMIT_SINK_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_retired <= '0;
            perf_stalls  <= '0;
        end else begin
            if (retire_valid)
                perf_retired <= perf_retired + 44'd1;
            if (wb_valid && !wb_ready)
                perf_stalls <= perf_stalls + 44'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_commit_sink.sv
// Randomized scoreboard bench for vx_commit_sink: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_vx_commit_sink;
    localparam int NL   = 4;
    localparam int PIDW = 2;
    localparam int UW   = 44;
    localparam int NW   = 2;
    localparam int PCB  = 30;
    localparam int NRB  = 5;
    localparam int XL   = 32;
    localparam int RRW  = 4;
    localparam int DW   = NL * XL;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_wb, in_sop, in_eop, in_ready;
    logic [UW-1:0]   in_uuid;
    logic [NW-1:0]   in_wid;
    logic [NL-1:0]   in_tmask;
    logic [PCB-1:0]  in_PC;
    logic [NRB-1:0]  in_rd;
    logic [DW-1:0]   in_data;
    logic [PIDW-1:0] in_pid;
    logic [RRW-1:0]  in_rrs_id;
    logic wb_valid, wb_we, wb_ready;
    logic [NW-1:0]   wb_wid;
    logic [NRB-1:0]  wb_rd;
    logic [NL-1:0]   wb_tmask;
    logic [DW-1:0]   wb_data;
    logic [PIDW-1:0] wb_pid;
    logic [RRW-1:0]  wb_rrs_id;
    logic retire_valid, err;
    logic [NW-1:0]   retire_wid, err_wid;
    logic [RRW-1:0]  retire_rrs_id;
`ifdef COMMIT_SINK_PERF_EN
    logic [43:0] perf_retired, perf_stalls;
`endif

    always #5 clk = ~clk;

    vx_commit_sink #(.NUM_LANES(NL), .PID_WIDTH(PIDW), .UUID_WIDTH(UW), .NW_WIDTH(NW),
                     .PC_BITS(PCB), .NR_BITS(NRB), .XLEN(XL), .RRS_WIS_W(RRW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_uuid(in_uuid), .in_wid(in_wid), .in_tmask(in_tmask),
        .in_PC(in_PC), .in_wb(in_wb), .in_rd(in_rd), .in_data(in_data), .in_pid(in_pid),
        .in_sop(in_sop), .in_eop(in_eop), .in_rrs_id(in_rrs_id), .in_ready(in_ready),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_wid(wb_wid), .wb_rd(wb_rd),
        .wb_tmask(wb_tmask), .wb_data(wb_data), .wb_pid(wb_pid), .wb_rrs_id(wb_rrs_id),
        .wb_ready(wb_ready),
        .retire_valid(retire_valid), .retire_wid(retire_wid), .retire_rrs_id(retire_rrs_id),
        .err(err), .err_wid(err_wid)
`ifdef COMMIT_SINK_PERF_EN
        , .perf_retired(perf_retired), .perf_stalls(perf_stalls)
`endif
    );

    typedef struct {
        logic [NW-1:0]   wid;
        logic [NL-1:0]   tmask;
        logic            we;
        logic [NRB-1:0]  rd;
        logic [PIDW-1:0] pid;
        logic [RRW-1:0]  rrs;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t wbq[$];
    int n_tests = 0, n_fail = 0, n_ret = 0, n_pop = 0;
    bit model_on = 0;
    bit rnd_done = 0;
    logic [(1<<NW)-1:0] m_inflight;
    bit m_err, exp_ret;
    logic [NW-1:0] m_err_wid, exp_ret_wid;
    logic [RRW-1:0] exp_ret_rrs;
    longint m_retired, m_stalls;

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        wbq.delete();
        m_inflight = '0;
        m_err = 0;
        m_err_wid = '0;
        exp_ret = 0;
        m_retired = 0;
        m_stalls = 0;
    endfunction

    // monitor: compares what the DUT shows against the model state
    always @(negedge clk) if (model_on) begin
        chk("in_ready", in_ready, wbq.size() < 2);
        chk("wb_valid", wb_valid, wbq.size() > 0);
        if (wb_valid && wbq.size() > 0) begin
            chk("wb_wid",   wb_wid,    wbq[0].wid);
            chk("wb_we",    wb_we,     wbq[0].we);
            chk("wb_rd",    wb_rd,     wbq[0].rd);
            chk("wb_tmask", wb_tmask,  wbq[0].tmask);
            chk("wb_pid",   wb_pid,    wbq[0].pid);
            chk("wb_rrs",   wb_rrs_id, wbq[0].rrs);
            chk("wb_data",  wb_data,   wbq[0].data);
            if (wb_ready) begin
                void'(wbq.pop_front());
                n_pop++;
            end
        end
        chk("retire_valid", retire_valid, exp_ret);
        if (exp_ret && retire_valid) begin
            chk("retire_wid", retire_wid, exp_ret_wid);
            chk("retire_rrs", retire_rrs_id, exp_ret_rrs);
        end
        chk("err", err, m_err);
        chk("err_wid", err_wid, m_err_wid);
`ifdef COMMIT_SINK_PERF_EN
        chk("perf_retired", perf_retired, m_retired);
        chk("perf_stalls", perf_stalls, m_stalls);
`endif
        if (retire_valid) begin
            n_ret++;
            m_retired++;
        end
        if (wb_valid && !wb_ready) m_stalls++;
    end

    // model update: whatever is accepted at the coming edge becomes an expectation
    always @(negedge clk) if (model_on) begin
        #1;
        exp_ret = 0;
        if (in_valid && in_ready) begin
            wbq.push_back('{wid: in_wid, tmask: in_tmask, we: in_wb && (in_tmask != 0),
                            rd: in_rd, pid: in_pid, rrs: in_rrs_id, data: in_data});
            exp_ret     = in_eop;
            exp_ret_wid = in_wid;
            exp_ret_rrs = in_rrs_id;
            if ((in_sop && m_inflight[in_wid]) || (!in_sop && !m_inflight[in_wid])) begin
                if (!m_err) begin
                    m_err = 1;
                    m_err_wid = in_wid;
                end
            end
            if (in_sop && !in_eop) m_inflight[in_wid] = 1'b1;
            if (!in_sop && in_eop) m_inflight[in_wid] = 1'b0;
        end
    end

    // starts and ends at posedge+1; holds the packet until accepted
    task automatic send(input logic [NW-1:0] wid, input bit sop, input bit eop,
                        input logic [PIDW-1:0] pid, input bit wb, input logic [NRB-1:0] rd,
                        input logic [NL-1:0] tmask, input logic [RRW-1:0] rrs);
        logic [DW-1:0] d;
        int t = 0;
        for (int i = 0; i < NL; i++) d[i*XL +: XL] = $urandom;
        in_valid = 1; in_wid = wid; in_sop = sop; in_eop = eop; in_pid = pid;
        in_wb = wb; in_rd = rd; in_tmask = tmask; in_rrs_id = rrs; in_data = d;
        in_uuid = {12'd0, $urandom}; in_PC = PCB'($urandom);
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for wid %0d", wid);
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, p0;
        reset = 1; in_valid = 0; in_uuid = '0; in_wid = '0; in_tmask = '0; in_PC = '0;
        in_wb = 0; in_rd = '0; in_data = '0; in_pid = '0; in_sop = 0; in_eop = 0;
        in_rrs_id = '0; wb_ready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_retire", retire_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_err_wid", err_wid, 0);
        model_clear();
        model_on = 1;

        // single packet: visible and retired one cycle after accept
        wb_ready = 1;
        send(2, 1, 1, 0, 1, 5, 4'hF, 3);
        chk("t1_wb_valid", wb_valid, 1);
        chk("t1_wb_we", wb_we, 1);
        chk("t1_wb_rd", wb_rd, 5);
        chk("t1_retire", retire_valid, 1);
        chk("t1_retire_wid", retire_wid, 2);
        chk("t1_err", err, 0);
        idle(1);

        // stalled writeback: A,B fill the buffer, C waits for the drain
        wb_ready = 0;
        p0 = n_pop;
        fork
            begin
                send(0, 1, 1, 0, 1, 1, 4'h1, 1);
                send(1, 1, 1, 1, 1, 2, 4'h3, 2);
                send(2, 1, 1, 2, 0, 3, 4'h7, 5);
            end
            begin
                idle(6);
                chk("t2_full_in_ready", in_ready, 0);
                wb_ready = 1;
            end
        join
        idle(3);
        chk("t2_pops", n_pop - p0, 3);

        // three-packet instruction on warp 1 retires once, at the eop
        r0 = n_ret;
        send(1, 1, 0, 0, 1, 7, 4'hF, 6);
        chk("t3_no_ret0", retire_valid, 0);
        send(1, 0, 0, 1, 1, 7, 4'hF, 6);
        chk("t3_no_ret1", retire_valid, 0);
        send(1, 0, 1, 2, 1, 7, 4'hF, 6);
        chk("t3_ret", retire_valid, 1);
        chk("t3_ret_wid", retire_wid, 1);
        idle(2);
        chk("t3_ret_count", n_ret - r0, 1);

        // orphan eop on warp 3 flags error; a later violation keeps err_wid
        send(3, 0, 1, 0, 1, 9, 4'h5, 8);
        chk("t4_err", err, 1);
        chk("t4_err_wid", err_wid, 3);
        chk("t4_forwarded", wb_valid, 1);
        send(0, 0, 0, 0, 1, 9, 4'h5, 8);
        idle(1);
        chk("t4_err_wid_kept", err_wid, 3);

        // sustained pop+accept at occupancy 1
        idle(2);
        r0 = n_ret; p0 = n_pop;
        for (int i = 0; i < 20; i++)
            send(NW'(i % 4), 1, 1, PIDW'(i), 1, NRB'(i), 4'hF, RRW'(i));
        idle(3);
        chk("t5_retires", n_ret - r0, 20);
        chk("t5_pops", n_pop - p0, 20);

        // random traffic with random backpressure and occasional violations
        rnd_done = 0;
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    wb_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [NW-1:0] w;
                    bit s, e;
                    w = NW'($urandom_range(0, 3));
                    s = !m_inflight[w];
                    e = $urandom_range(0, 1);
                    if ($urandom_range(0, 15) == 0) s = !s;
                    send(w, s, e, PIDW'($urandom), $urandom_range(0, 1), NRB'($urandom),
                         NL'($urandom_range(0, 15)), RRW'($urandom));
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rnd_done = 1;
            end
        join
        wb_ready = 1;
        idle(5);
        chk("drain_empty", wbq.size(), 0);

        // reset with two entries buffered and an open sequence
        wb_ready = 0;
        send(1, !m_inflight[1], 0, 0, 1, 4, 4'hF, 2);
        send(1, 0, 0, 1, 1, 4, 4'hF, 2);
        #2;
        model_on = 0;
        reset = 1;
        #1;
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_retire", retire_valid, 0);
        chk("mid_rst_err", err, 0);
`ifdef COMMIT_SINK_PERF_EN
        chk("mid_rst_perf", perf_retired, 0);
`endif
        idle(2);
        reset = 0;
        model_clear();
        model_on = 1;
        r0 = n_ret;
        wb_ready = 1;
        idle(5);
        chk("post_rst_no_retire", n_ret - r0, 0);
        send(1, 1, 1, 0, 1, 6, 4'hA, 1);
        idle(2);
        chk("post_rst_retire", n_ret - r0, 1);

        model_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
